pwm_duty_capture_module: RTL and testbench
==========================================

// Module: pwm_duty_capture_module
// PURPOSE
//  Receive side of the key-selectable PWM link: measures an incoming PWM line and reports duty in 1/256 units.
//  Time quantum = one segment of SEG_CLKS clocks; nominal period = 256 segments (~1 kHz at 50 MHz).
//  Reports high-time (duty) and full period once per period; flags a stuck line (0 % / 100 %) via timeout.
//  Sits between the PWM pin and downstream display/compare logic.
// PARAMETERS
//  SEG_CLKS      196    clocks per segment (prescaler terminal count + 1)
//  TIMEOUT_SEGS  1024   segments without any edge before line is declared stuck
//  PERIOD_W      10     width of period_segs output
// PORTS
//  CLK          in   1         system clock
//  RSTn         in   1         reset, asynchronous, active-low
//  pwm_in       in   1         asynchronous PWM line
//  duty         out  8         last measured high time in segments, saturated at 255
//  period_segs  out  PERIOD_W  last measured period in segments, saturated at all-ones
//  duty_valid   out  1         one-cycle strobe: duty/period_segs just updated
//  stuck        out  1         1 = no edge for TIMEOUT_SEGS segments
// BEHAVIOUR
//  Reset (async): all outputs 0; FSM = IDLE; sync flops = 0; all counters 0.
//  Input: 2-FF synchroniser + 1 history flop; rise/fall pulses 3 CLK after pin edge; all logic uses synced level.
//  Prescaler: 0..SEG_CLKS-1, reset to 0 on every detected edge; seg_tick when prescaler == SEG_CLKS-1.
//  Rounding: on an edge, phase counter (high_segs or low_segs) adds 1 if prescaler >= SEG_CLKS/2 (integer).
//  high_segs, low_segs: 9-bit internal, saturate at 511, cleared on entry to HIGH (from rise).
//  FSM:
//   IDLE : wait for rise -> HIGH. Falls ignored (no complete period yet).
//   HIGH : count seg_ticks into high_segs; fall -> LOW.
//   LOW  : count seg_ticks into low_segs; rise -> publish, then HIGH (new period starts same cycle).
//   STUCK: stuck=1; rise -> HIGH (stuck cleared same cycle); fall -> LOW with high_segs=0 (stuck cleared).
//  Publish (cycle after rise pulse): duty = min(high_segs,255); period_segs = min(high_segs+low_segs, 2^PERIOD_W-1);
//   duty_valid = 1 for exactly that cycle.
//  Timeout: edge_gap counts seg_ticks since last edge (any state); reaching TIMEOUT_SEGS -> STUCK:
//   duty = 255 if synced level high else 0; period_segs = 0; duty_valid pulses once; stuck = 1.
//   edge_gap holds in STUCK (no repeated strobes) until next edge.
//  Simultaneous: edge and timeout in same cycle -> edge wins, no STUCK entry.
//  First period after IDLE or STUCK: measured normally; publish only on the rise that closes a HIGH+LOW pair.
//  Reset mid-period: measurement discarded, outputs 0, restart in IDLE.
//  Outputs registered; hold value between strobes.
// TESTING
//  Reset: assert RSTn=0 mid-period -> duty=0, period_segs=0, duty_valid=0, stuck=0 next cycle; no strobe until two rises later.
//  50 %: high 128*196 clk, low 128*196 clk, repeat -> each rise after the first: duty=128, period_segs=256, 1-cycle duty_valid.
//  20 %: high 51*196, low 205*196 -> duty=51, period_segs=256; high 51*196+98 clk -> duty=52 (round up).
//  0 % / 100 %: hold pwm_in=0 -> after 1024 segs stuck=1, duty=0, one strobe; hold 1 -> duty=255; then rise -> stuck=0.
//  Saturation: high 300 segs, low 10 segs -> duty=255, period_segs=310.
//  Edge vs timeout: rise exactly on 1024th seg_tick -> no STUCK, stuck stays 0, measurement continues.

Source files
------------

// File: rtl/pwm_duty_capture_module.sv
// PWM receive-side duty/period meter: measures high and low time of an asynchronous
// PWM line in segments of SEG_CLKS clocks, publishes once per period, flags a stuck line.
module pwm_duty_capture_module #(
    parameter int SEG_CLKS     = 196,
    parameter int TIMEOUT_SEGS = 1024,
    parameter int PERIOD_W     = 10
) (
    input  logic                CLK,
    input  logic                RSTn,
    input  logic                pwm_in,
    output logic [7:0]          duty,
    output logic [PERIOD_W-1:0] period_segs,
    output logic                duty_valid,
    output logic                stuck
);

    localparam int PRESC_W = (SEG_CLKS > 1) ? $clog2(SEG_CLKS) : 1;
    localparam int GAP_W   = $clog2(TIMEOUT_SEGS + 1);
    localparam int PER_MAX = (1 << PERIOD_W) - 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SEG_CLKS - 1);
    // The edge cycle itself completes clock presc+1 of the segment, hence the -1.
    localparam logic [PRESC_W-1:0] RND_THR    = PRESC_W'(SEG_CLKS / 2 - 1);
    localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(TIMEOUT_SEGS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HIGH  = 2'd1,
        ST_LOW   = 2'd2,
        ST_STUCK = 2'd3
    } state_t;

    function automatic logic [8:0] sat_inc9(input logic [8:0] val, input logic inc);
        logic [8:0] res;
        if (inc && (val != 9'h1FF)) begin
            res = val + 9'd1;
        end else begin
            res = val;
        end
        return res;
    endfunction

    state_t               state_q, state_d;
    logic                 sync1_q, sync2_q, hist_q;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic [8:0]           high_q, high_d;
    logic [8:0]           low_q, low_d;
    logic [7:0]           duty_q, duty_d;
    logic [PERIOD_W-1:0]  period_q, period_d;
    logic                 valid_q, valid_d;
    logic                 stuck_q, stuck_d;

    logic                 rise_s, fall_s, edge_s;
    logic                 seg_tick_s, round_s, timeout_s;
    logic [8:0]           low_fin_s;
    logic [9:0]           sum_s;
    logic [PERIOD_W-1:0]  period_pub_s;
    logic [7:0]           duty_pub_s;

    assign rise_s     = sync2_q & ~hist_q;
    assign fall_s     = ~sync2_q & hist_q;
    assign edge_s     = rise_s | fall_s;
    // A tick coinciding with an edge is folded into the rounding step instead.
    assign seg_tick_s = (presc_q == PRESC_LAST) & ~edge_s;
    assign round_s    = (presc_q >= RND_THR);
    assign timeout_s  = seg_tick_s & (state_q != ST_STUCK) & (gap_q == GAP_LAST);

    assign low_fin_s    = sat_inc9(low_q, round_s);
    assign sum_s        = {1'b0, high_q} + {1'b0, low_fin_s};
    assign period_pub_s = (int'(sum_s) > PER_MAX) ? PERIOD_W'(PER_MAX) : PERIOD_W'(sum_s);
    assign duty_pub_s   = (high_q > 9'd255) ? 8'hFF : high_q[7:0];

    // Prescaler and edge-gap counter next state.
    always_comb begin
        presc_d = presc_q;
        gap_d   = gap_q;
        if (edge_s) begin
            presc_d = '0;
        end else if (presc_q == PRESC_LAST) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PRESC_W'(1);
        end
        if (edge_s) begin
            gap_d = '0;
        end else if (seg_tick_s && (state_q != ST_STUCK)) begin
            gap_d = gap_q + GAP_W'(1);
        end else begin
            gap_d = gap_q;
        end
    end

    // Measurement FSM: phase counters, publish and stuck reporting.
    always_comb begin
        state_d  = state_q;
        high_d   = high_q;
        low_d    = low_q;
        duty_d   = duty_q;
        period_d = period_q;
        valid_d  = 1'b0;
        stuck_d  = stuck_q;
        case (state_q)
            ST_IDLE: begin
                if (rise_s) begin
                    state_d = ST_HIGH;
                    high_d  = 9'd0;
                    low_d   = 9'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HIGH: begin
                if (fall_s) begin
                    state_d = ST_LOW;
                    high_d  = sat_inc9(high_q, round_s);
                end else begin
                    high_d  = sat_inc9(high_q, seg_tick_s);
                end
            end
            ST_LOW: begin
                if (rise_s) begin
                    duty_d   = duty_pub_s;
                    period_d = period_pub_s;
                    valid_d  = 1'b1;
                    state_d  = ST_HIGH;
                    high_d   = 9'd0;
                    low_d    = 9'd0;
                end else begin
                    low_d    = sat_inc9(low_q, seg_tick_s);
                end
            end
            ST_STUCK: begin
                if (rise_s) begin
                    state_d = ST_HIGH;
                    high_d  = 9'd0;
                    low_d   = 9'd0;
                    stuck_d = 1'b0;
                end else if (fall_s) begin
                    state_d = ST_LOW;
                    high_d  = 9'd0;
                    low_d   = 9'd0;
                    stuck_d = 1'b0;
                end else begin
                    state_d = ST_STUCK;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Timeout never coincides with an edge, so it can override the phase update.
        if (timeout_s) begin
            state_d  = ST_STUCK;
            stuck_d  = 1'b1;
            duty_d   = sync2_q ? 8'hFF : 8'h00;
            period_d = '0;
            valid_d  = 1'b1;
        end else begin
            stuck_d  = stuck_d;
        end
    end

    // State, synchroniser and output registers.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q  <= ST_IDLE;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            hist_q   <= 1'b0;
            presc_q  <= '0;
            gap_q    <= '0;
            high_q   <= 9'd0;
            low_q    <= 9'd0;
            duty_q   <= 8'd0;
            period_q <= '0;
            valid_q  <= 1'b0;
            stuck_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync1_q  <= pwm_in;
            sync2_q  <= sync1_q;
            hist_q   <= sync2_q;
            presc_q  <= presc_d;
            gap_q    <= gap_d;
            high_q   <= high_d;
            low_q    <= low_d;
            duty_q   <= duty_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            stuck_q  <= stuck_d;
        end
    end

    assign duty        = duty_q;
    assign period_segs = period_q;
    assign duty_valid  = valid_q;
    assign stuck       = stuck_q;

endmodule

// File: tb/tb_pwm_duty_capture_module.sv
// Bench for pwm_duty_capture_module: pin-level interval stimulus against a period-level
// reference model that predicts every duty_valid strobe.
module tb_pwm_duty_capture_module;

    localparam int SEG = 8;
    localparam int TO  = 1024;
    localparam int PW  = 10;
    localparam int PMAX = (1 << PW) - 1;

    logic          CLK = 1'b0;
    logic          RSTn;
    logic          pwm_in;
    logic [7:0]    duty;
    logic [PW-1:0] period_segs;
    logic          duty_valid;
    logic          stuck;

    pwm_duty_capture_module #(
        .SEG_CLKS(SEG), .TIMEOUT_SEGS(TO), .PERIOD_W(PW)
    ) dut (
        .CLK(CLK), .RSTn(RSTn), .pwm_in(pwm_in), .duty(duty),
        .period_segs(period_segs), .duty_valid(duty_valid), .stuck(stuck)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    typedef struct {
        int duty;
        int per;
        int stk;
    } ev_t;

    ev_t exp_q[$];

    // Model: phase 0 = no rise seen, 1 = high being timed, 2 = high known, low being timed.
    int phase;
    int hi_meas;
    int prev_lv;
    int prev_len;
    bit prev_open;
    int last_duty;
    logic dv_prev;

    function automatic int segs_of(input int e);
        int s;
        s = e / SEG + (((e % SEG) >= SEG / 2) ? 1 : 0);
        return (s > 511) ? 511 : s;
    endfunction

    task automatic push_ev(input int d, input int p, input int s);
        ev_t ev;
        ev.duty = d;
        ev.per  = p;
        ev.stk  = s;
        exp_q.push_back(ev);
        last_duty = d;
    endtask

    // The pin edge now being driven ends the previous interval.
    task automatic close_prev();
        int s;
        if (prev_len > TO * SEG) begin
            if (prev_lv == 1) begin
                phase   = 2;
                hi_meas = 0;
            end else begin
                phase = 1;
            end
        end else if (prev_lv == 1) begin
            if (phase == 1) begin
                hi_meas = segs_of(prev_len);
                phase   = 2;
            end
        end else begin
            if (phase == 2) begin
                s = hi_meas + segs_of(prev_len);
                push_ev((hi_meas > 255) ? 255 : hi_meas, (s > PMAX) ? PMAX : s, 0);
            end
            phase = 1;
        end
    endtask

    task automatic drive(input int lv, input int len);
        if (prev_open) close_prev();
        if (len > TO * SEG) push_ev((lv == 1) ? 255 : 0, 0, 1);
        pwm_in = (lv == 1);
        if (prev_open && (prev_len > TO * SEG)) begin
            repeat (6) @(negedge CLK);
            check_val("stuck_clr", int'(stuck), 0);
            repeat (len - 6) @(negedge CLK);
        end else begin
            repeat (len) @(negedge CLK);
        end
        prev_lv   = lv;
        prev_len  = len;
        prev_open = 1'b1;
    endtask

    // Strobe monitor: every duty_valid pulse must match the next predicted event.
    always @(negedge CLK) begin
        if (RSTn === 1'b1 && duty_valid === 1'b1) begin
            ev_t e;
            check_val("dv_pulse", int'(dv_prev), 0);
            check_val("ev_pending", int'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_val("duty", int'(duty), e.duty);
                check_val("period", int'(period_segs), e.per);
                check_val("stuck", int'(stuck), e.stk);
            end
        end
        dv_prev = duty_valid;
    end

    initial begin
        int lv;
        RSTn      = 1'b0;
        pwm_in    = 1'b0;
        phase     = 0;
        hi_meas   = 0;
        prev_open = 1'b0;
        prev_lv   = 0;
        prev_len  = 0;
        last_duty = 0;
        dv_prev   = 1'b0;
        repeat (3) @(negedge CLK);
        check_val("rst_duty", int'(duty), 0);
        check_val("rst_period", int'(period_segs), 0);
        check_val("rst_valid", int'(duty_valid), 0);
        check_val("rst_stuck", int'(stuck), 0);
        RSTn = 1'b1;
        prev_open = 1'b1;
        prev_lv   = 0;
        prev_len  = 10;
        repeat (10) @(negedge CLK);

        // 50 % duty
        for (int i = 0; i < 3; i++) begin
            drive(1, 128 * SEG);
            drive(0, 128 * SEG);
        end
        // 20 % duty, then half-segment round-up
        drive(1, 51 * SEG);
        drive(0, 205 * SEG);
        drive(1, 51 * SEG + SEG / 2);
        drive(0, 205 * SEG);
        // high-time saturation
        drive(1, 300 * SEG);
        drive(0, 10 * SEG);
        // edge lands on the final timeout tick
        drive(1, 10 * SEG);
        drive(0, TO * SEG);
        drive(1, 20 * SEG);
        // stuck low, then stuck high, then leave by a fall
        drive(0, TO * SEG + 50);
        drive(1, TO * SEG + 50);
        drive(0, 40 * SEG);

        lv = 1;
        for (int i = 0; i < 16; i++) begin
            drive(lv, int'($urandom_range(1, 200)) * SEG + int'($urandom_range(0, SEG - 1)));
            lv = 1 - lv;
        end

        // Reset in the middle of a high phase
        close_prev();
        prev_open = 1'b0;
        pwm_in = 1'b1;
        repeat (20) @(negedge CLK);
        check_val("pre_rst_q", exp_q.size(), 0);
        RSTn   = 1'b0;
        pwm_in = 1'b0;
        #1;
        check_val("mid_rst_duty", int'(duty), 0);
        check_val("mid_rst_period", int'(period_segs), 0);
        check_val("mid_rst_valid", int'(duty_valid), 0);
        check_val("mid_rst_stuck", int'(stuck), 0);
        repeat (3) @(negedge CLK);
        RSTn      = 1'b1;
        phase     = 0;
        last_duty = 0;
        prev_open = 1'b1;
        prev_lv   = 0;
        prev_len  = 10;
        repeat (10) @(negedge CLK);
        drive(1, 64 * SEG);
        drive(0, 64 * SEG);
        drive(1, 30 * SEG);

        repeat (20) @(negedge CLK);
        check_val("end_q_empty", exp_q.size(), 0);
        check_val("hold_duty", int'(duty), last_duty);
        check_val("end_stuck", int'(stuck), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
